// File: rtl/seq101_pkg.sv
// Shared encodings for the 101 detector family and its stimulus transmitter.
// Detector states are reused by the reference tracker.
package seq101_pkg;

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SHIFT = 2'b01;
    localparam logic [1:0] GAP   = 2'b10;

    // Mealy 101 next-state; a detection is S2 seeing a 1.
    function automatic logic [1:0] trk_next(
        input logic [1:0] s,
        input logic       b
    );
        logic [1:0] n;
        n = S0;
        case (s)
            S0:      n = b ? S1 : S0;
            S1:      n = b ? S1 : S2;
            S2:      n = b ? S1 : S0;
            default: n = S0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Load handshake and serial output bundle of serial_pattern_tx.
// master = stimulus side, slave = transmitter.
interface serial_pattern_tx_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             abort;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;
    logic             expect_detect;

    modport master (
        output load_valid,
        output load_data,
        output abort,
        input  load_ready,
        input  out,
        input  out_valid,
        input  busy,
        input  done,
        input  expect_detect
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  abort,
        output load_ready,
        output out,
        output out_valid,
        output busy,
        output done,
        output expect_detect
    );
endinterface

// File: rtl/seq101_tracker.sv
// Reference Mealy 101 detector; detect is registered like the real one.
// It samples every bit, idle and gap zeros included.
module seq101_tracker
    import seq101_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic bit_in,
    output logic detect
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       detect_q;
    logic       detect_d;

    always_comb begin
        state_d  = trk_next(state_q, bit_in);
        detect_d = (state_q == S2) && bit_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S0;
            detect_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            detect_q <= detect_d;
        end
    end

    assign detect = detect_q;

endmodule

// File: rtl/serial_pattern_tx.sv
// MSB-first serial word transmitter with idle gap and a built-in
// reference model predicting the downstream 101 detector.
module serial_pattern_tx
    import seq101_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_pattern_tx_if.slave bus
);

    localparam int BCW = $clog2(WIDTH);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [3:0] GAP_LAST =
        4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
    localparam logic [1:0] AFTER_WORD =
        (GAP_CYCLES > 0) ? GAP : IDLE;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [BCW-1:0]   bitcnt_q;
    logic [BCW-1:0]   bitcnt_d;
    logic [3:0]       gapcnt_q;
    logic [3:0]       gapcnt_d;
    logic             done_q;
    logic             done_d;
    logic             tx_bit;
    logic             det;

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        gapcnt_d = gapcnt_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // abort is meaningless here, so a coincident load wins
                if (bus.load_valid) begin
                    shreg_d  = bus.load_data;
                    bitcnt_d = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.abort) begin
                    shreg_d = '0;
                    state_d = IDLE;
                end else begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    if (bitcnt_q == BIT_LAST) begin
                        done_d   = 1'b1;
                        gapcnt_d = '0;
                        state_d  = AFTER_WORD;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
            GAP: begin
                if (bus.abort || gapcnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gapcnt_d = gapcnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            gapcnt_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            gapcnt_q <= gapcnt_d;
            done_q   <= done_d;
        end
    end

    assign tx_bit = (state_q == SHIFT) && shreg_q[WIDTH-1];

    seq101_tracker u_trk (
        .clk    (clk),
        .rst_n  (rst_n),
        .bit_in (tx_bit),
        .detect (det)
    );

    assign bus.load_ready    = (state_q == IDLE);
    assign bus.out           = tx_bit;
    assign bus.out_valid     = (state_q == SHIFT);
    assign bus.busy          = (state_q != IDLE);
    assign bus.done          = done_q;
    assign bus.expect_detect = det;

endmodule
